// File: rtl/sw_debounce.sv
// Multi-bit switch debouncer: per-bit synchronizer and stability counter,
// with a valid/ready change-event channel that coalesces unaccepted changes.
module sw_debounce #(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] evt_data_o,
    output logic [WIDTH-1:0] evt_mask_o,
    output logic [7:0]       ovf_cnt_o
);

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] q_s;
    logic [15:0]      cnt_r      [WIDTH];
    logic [15:0]      cnt_next_s [WIDTH];
    logic [WIDTH-1:0] sw_r;
    logic [WIDTH-1:0] sw_next_s;
    logic [WIDTH-1:0] chg_s;
    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_next_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] mask_next_s;
    logic [7:0]       ovf_r;
    logic [7:0]       ovf_next_s;

    // Synchronizer chain for the raw asynchronous switch levels.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= sw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign q_s = sync_r[SYNC_STAGES-1];

    // Per-bit stability window; any return to the stable level restarts it.
    always_comb begin
        sw_next_s = sw_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i] = 16'd0;
            if (q_s[i] != sw_r[i]) begin
                if (cnt_r[i] == CNT_LAST) begin
                    sw_next_s[i]  = q_s[i];
                    cnt_next_s[i] = 16'd0;
                end else begin
                    cnt_next_s[i] = cnt_r[i] + 16'd1;
                end
            end else begin
                cnt_next_s[i] = 16'd0;
            end
        end
    end

    assign chg_s = sw_next_s ^ sw_r;

    // Counter and debounced-level registers.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sw_r <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= 16'd0;
            end
        end else begin
            sw_r <= sw_next_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Event handshake: new change while pending either replaces (on transfer) or merges.
    always_comb begin
        state_next_s = state_r;
        data_next_s  = data_r;
        mask_next_s  = mask_r;
        ovf_next_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (chg_s != '0) begin
                    state_next_s = PEND;
                    data_next_s  = sw_next_s;
                    mask_next_s  = chg_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PEND: begin
                if (evt_ready_i) begin
                    if (chg_s == '0) begin
                        state_next_s = IDLE;
                        mask_next_s  = '0;
                    end else begin
                        data_next_s = sw_next_s;
                        mask_next_s = chg_s;
                    end
                end else if (chg_s != '0) begin
                    data_next_s = sw_next_s;
                    mask_next_s = mask_r | chg_s;
                    ovf_next_s  = (ovf_r == 8'hFF) ? ovf_r : ovf_r + 8'd1;
                end else begin
                    state_next_s = PEND;
                end
            end
            default: begin
                state_next_s = IDLE;
                mask_next_s  = '0;
            end
        endcase
    end

    // Handshake state and event payload registers.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            data_r  <= '0;
            mask_r  <= '0;
            ovf_r   <= 8'd0;
        end else begin
            state_r <= state_next_s;
            data_r  <= data_next_s;
            mask_r  <= mask_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign sw_o        = sw_r;
    assign evt_valid_o = (state_r == PEND);
    assign evt_data_o  = data_r;
    assign evt_mask_o  = mask_r;
    assign ovf_cnt_o   = ovf_r;

endmodule
